serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
- REQ-001: Parameter W SHALL default to 4 and set the operand and result width in bits, legal range 2..32.
- REQ-002: clk  input  1  single clock; all state SHALL update on the rising edge.
- REQ-003: reset_n  input  1  reset, asynchronous and active-low.
- REQ-004: start  input  1  request to compute x - y - bin; SHALL be sampled only while ready=1.
- REQ-005: x  input  W  minuend, sampled with start.
- REQ-006: y  input  W  subtrahend, sampled with start.
- REQ-007: bin  input  1  borrow-in, sampled with start.
- REQ-008: ready  output  1  SHALL be high in IDLE only.
- REQ-009: busy  output  1  SHALL be high in SHIFT only.
- REQ-010: done  output  1  SHALL be a one-cycle pulse when the result becomes valid.
- REQ-011: d  output  W  difference; SHALL hold its value from done until the next accepted start.
- REQ-012: bout  output  1  borrow-out of the MSB; SHALL hold with d.

Function
- REQ-013: The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
- REQ-014: In IDLE, start=1 SHALL perform all of the following on that edge:
  - latch x, y and bin into internal registers;
  - clear the bit counter;
  - move to SHIFT.
- REQ-015: Each SHIFT cycle SHALL process one bit, LSB first, using the current borrow b:
  - difference bit = x_i ^ y_i ^ b;
  - next borrow = (~x_i & y_i) | (~(x_i ^ y_i) & b).
- REQ-016: The block SHALL stay in SHIFT for exactly W cycles, then move to DONE.
- REQ-017: DONE SHALL last one cycle with done=1, then return to IDLE.
- REQ-018: Latency: if start is accepted at edge T, done SHALL be high during cycle T+W+1 and ready SHALL be high again from T+W+2.
- REQ-019: Arithmetic SHALL be modulo 2^W.
- REQ-020: bout SHALL be 1 if and only if x < y + bin as unsigned values.
- REQ-021: start while busy=1 or done=1 SHALL be ignored, with no effect on the result or the FSM.
- REQ-022: Input changes on x, y or bin after acceptance SHALL NOT affect the result.
- REQ-023: d and bout SHALL NOT change during SHIFT; partial results are held internally and copied to d and bout when the FSM enters DONE.

Reset
- REQ-024: While reset_n=0 the outputs SHALL take these values:
  - state = IDLE;
  - ready = 1;
  - busy = 0;
  - done = 0;
  - d = 0;
  - bout = 0;
  - all internal registers = 0.
- REQ-025: Reset asserted mid-operation SHALL abort the operation immediately; no done pulse SHALL follow.
- REQ-026: The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Configuration
- REQ-027: Macro SERIAL_SUB_OVF_EN defined: the block SHALL have an extra output ovf (1 bit, registered with d) as follows:
  - ovf = (x[W-1] != y[W-1]) & (d[W-1] != x[W-1]), the two's-complement signed overflow of x - y - bin;
  - ovf SHALL reset to 0 and hold with d.
- REQ-028: Macro SERIAL_SUB_OVF_EN undefined: the ovf port and its logic SHALL be absent.

Verification (W=4)
- REQ-029: x=9, y=3, bin=0, start -> done exactly 5 cycles after the accept edge; d=6, bout=0.
- REQ-030: x=3, y=9, bin=0 -> d=0xA, bout=1.
- REQ-031: x=0, y=0, bin=1 -> d=0xF, bout=1; then x=0xF, y=0xF, bin=0 -> d=0, bout=0.
- REQ-032: Start 9-3, pulse start again with 1-1 during SHIFT cycle 2 -> second start ignored; d=6; ready returns after DONE.
- REQ-033: Start 9-3, assert reset_n=0 during SHIFT cycle 3 -> immediate IDLE with d=0, bout=0, ready=1, and no done pulse.
- REQ-034: With SERIAL_SUB_OVF_EN: x=7, y=8, bin=0 -> d=0xF, bout=1, ovf=1; x=5, y=2 -> d=3, ovf=0.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Purpose: operand/result bundle between a requester and serial_subtractor.
// Latency: none; wires only.
// Backpressure: requester may raise start only while ready is high. Optional ovf exists only under SERIAL_SUB_OVF_EN.
interface serial_subtractor_if #(
   parameter int W = 4
);
   logic         start;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         bin;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         bout;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;

   modport master (output start, x, y, bin, input ready, busy, done, d, bout, ovf);
   modport slave  (input start, x, y, bin, output ready, busy, done, d, bout, ovf);
`else
   modport master (output start, x, y, bin, input ready, busy, done, d, bout);
   modport slave  (input start, x, y, bin, output ready, busy, done, d, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Purpose: bit-serial x - y - bin (mod 2^W), LSB first, one bit per cycle; SERIAL_SUB_OVF_EN adds signed-overflow flag ovf.
// Latency: start accepted at edge T -> done pulse in cycle T+W+1, ready again from T+W+2.
// Backpressure: start is sampled only in IDLE (ready=1); start during SHIFT/DONE is ignored.
module serial_subtractor #(
   parameter int W = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   serial_subtractor_if.slave   bus
);
   // W >= 2, so the counter is at least one bit and spans 0..W-1
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [W-1:0]  sx;       // minuend, shifted right each SHIFT cycle
   logic [W-1:0]  sy;       // subtrahend, shifted right each SHIFT cycle
   logic          b;        // running borrow
   logic [W-1:0]  sd;       // partial difference, filled from the MSB end
   logic [CW-1:0] cnt;      // bit index being processed
   logic [W-1:0]  d_q;
   logic          bout_q;

   logic          dbit;
   logic          bnxt;
   logic          last;
   logic [W-1:0]  d_nxt;

`ifdef SERIAL_SUB_OVF_EN
   logic          x_msb;    // original operand sign bits, lost once shifting starts
   logic          y_msb;
   logic          ovf_q;
`endif

   // one full-subtractor cell on the current LSBs
   always_comb begin
      dbit  = sx[0] ^ sy[0] ^ b;
      bnxt  = (~sx[0] & sy[0]) | (~(sx[0] ^ sy[0]) & b);
      d_nxt = {dbit, sd[W-1:1]};
      last  = (cnt == CW'(W - 1));
   end

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state and status outputs
   always_comb begin
      state_nxt = state;
      bus.ready = 1'b0;
      bus.busy  = 1'b0;
      bus.done  = 1'b0;
      case (state)
         IDLE: begin
            bus.ready = 1'b1;
            if (bus.start) state_nxt = SHIFT;
         end
         SHIFT: begin
            bus.busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            bus.done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // operand capture, serial datapath, and result registers (result only moves on the final bit)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sx     <= '0;
         sy     <= '0;
         b      <= 1'b0;
         sd     <= '0;
         cnt    <= '0;
         d_q    <= '0;
         bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         x_msb  <= 1'b0;
         y_msb  <= 1'b0;
         ovf_q  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sx    <= bus.x;
                  sy    <= bus.y;
                  b     <= bus.bin;
                  sd    <= '0;
                  cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                  x_msb <= bus.x[W-1];
                  y_msb <= bus.y[W-1];
`endif
               end
            end
            SHIFT: begin
               sx  <= sx >> 1;
               sy  <= sy >> 1;
               b   <= bnxt;
               sd  <= d_nxt;
               cnt <= cnt + 1'b1;
               if (last) begin
                  d_q    <= d_nxt;
                  bout_q <= bnxt;
`ifdef SERIAL_SUB_OVF_EN
                  ovf_q  <= (x_msb != y_msb) & (d_nxt[W-1] != x_msb);
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.d    = d_q;
   assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (W=4): directed cases, randomized operands, ignored starts, mid-operation reset.
// Reference results come from plain integer arithmetic on the operands.
// Build with SERIAL_SUB_OVF_EN defined to also check ovf.
module tb_serial_subtractor;
   localparam int W = 4;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   serial_subtractor_if #(.W(W)) bus ();

   serial_subtractor #(.W(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int ncmp  = 0;
   int nfail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // sample/drive point: 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] ref_d(input int x, input int y, input int bi);
      return W'(x - y - bi);
   endfunction

   function automatic logic ref_bout(input int x, input int y, input int bi);
      return (x < y + bi);
   endfunction

   function automatic logic ref_ovf(input int x, input int y, input int bi);
      int sx, sy, r;
      sx = (x >= (1 << (W - 1))) ? x - (1 << W) : x;
      sy = (y >= (1 << (W - 1))) ? y - (1 << W) : y;
      r  = sx - sy - bi;
      return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
   endfunction

   // One full transaction. poke>0 raises start (with 1-1) in that SHIFT cycle;
   // poke_done holds start high through the DONE cycle. Both must be ignored.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                         input int poke, input bit poke_done, input string tag);
      int           n;
      logic [W-1:0] hold_d;
      logic         hold_b;
      bit           bad_hold;
      logic [W-1:0] ed;
      logic         eb;

      ed = ref_d(int'(x), int'(y), int'(bi));
      eb = ref_bout(int'(x), int'(y), int'(bi));

      n = 0;
      while (!bus.ready && n < 50) begin
         tick();
         n++;
      end
      check({tag, ".ready"}, bus.ready, 1);

      hold_d      = bus.d;
      hold_b      = bus.bout;
      bus.x       = x;
      bus.y       = y;
      bus.bin     = bi;
      bus.start   = 1'b1;
      tick();                       // accept edge
      bus.start   = 1'b0;
      bus.x       = W'($urandom);
      bus.y       = W'($urandom);
      bus.bin     = 1'($urandom);
      check({tag, ".busy"}, bus.busy, 1);

      n        = 0;
      bad_hold = 1'b0;
      while (!bus.done && n < 3 * W) begin
         if (bus.d !== hold_d || bus.bout !== hold_b) bad_hold = 1'b1;
         if (poke > 0 && n + 1 == poke) begin
            bus.start = 1'b1;
            bus.x     = W'(1);
            bus.y     = W'(1);
            bus.bin   = 1'b0;
         end else begin
            bus.start = 1'b0;
         end
         tick();
         n++;
      end
      bus.start = 1'b0;
      check({tag, ".hold_in_shift"}, bad_hold, 0);
      // done occupies cycle T+W+1, i.e. it appears after the W-th edge following accept
      check({tag, ".latency"}, n, W);
      check({tag, ".done"}, bus.done, 1);
      check({tag, ".d"}, bus.d, ed);
      check({tag, ".bout"}, bus.bout, eb);
`ifdef SERIAL_SUB_OVF_EN
      check({tag, ".ovf"}, bus.ovf, ref_ovf(int'(x), int'(y), int'(bi)));
`endif
      if (poke_done) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check({tag, ".done_pulse"}, bus.done, 0);
      check({tag, ".ready_after"}, bus.ready, 1);
      check({tag, ".idle_not_busy"}, bus.busy, 0);
      check({tag, ".d_held"}, bus.d, ed);
      check({tag, ".bout_held"}, bus.bout, eb);
   endtask

   initial begin
      int  n;
      bit  saw_done;

      reset_n   = 1'b0;
      bus.start = 1'b0;
      bus.x     = '0;
      bus.y     = '0;
      bus.bin   = 1'b0;
      repeat (3) tick();
      check("rst.ready", bus.ready, 1);
      check("rst.busy", bus.busy, 0);
      check("rst.done", bus.done, 0);
      check("rst.d", bus.d, 0);
      check("rst.bout", bus.bout, 0);
`ifdef SERIAL_SUB_OVF_EN
      check("rst.ovf", bus.ovf, 0);
`endif
      reset_n = 1'b1;

      // first start right after reset release must be taken on the next edge
      run_op(4'd9, 4'd3, 1'b0, 0, 1'b0, "d9m3");
      run_op(4'd3, 4'd9, 1'b0, 0, 1'b0, "d3m9");
      run_op(4'd0, 4'd0, 1'b1, 0, 1'b0, "d0m0b1");
      run_op(4'hF, 4'hF, 1'b0, 0, 1'b0, "dFmF");
      run_op(4'd7, 4'd8, 1'b0, 0, 1'b0, "d7m8");
      run_op(4'd5, 4'd2, 1'b0, 0, 1'b0, "d5m2");
      run_op(4'd8, 4'd0, 1'b1, 0, 1'b0, "d8m0b1");

      // start during SHIFT cycle 2 and during DONE must both be ignored
      run_op(4'd9, 4'd3, 1'b0, 2, 1'b1, "ign9m3");

      // randomized operands
      for (int i = 0; i < 40; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, W)),
                1'($urandom), "rnd");
      end

      // reset during SHIFT cycle 3 aborts immediately, no done afterwards
      run_op(4'd9, 4'd3, 1'b0, 0, 1'b0, "pre_rst");
      bus.x     = 4'd9;
      bus.y     = 4'd3;
      bus.bin   = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      check("abort.in_shift", bus.busy, 1);
      reset_n = 1'b0;
      #1;
      check("abort.ready", bus.ready, 1);
      check("abort.busy", bus.busy, 0);
      check("abort.done", bus.done, 0);
      check("abort.d", bus.d, 0);
      check("abort.bout", bus.bout, 0);
      tick();
      reset_n  = 1'b1;
      saw_done = 1'b0;
      for (n = 0; n < W + 3; n++) begin
         if (bus.done) saw_done = 1'b1;
         tick();
      end
      check("abort.no_done", saw_done, 0);
      check("abort.idle", bus.ready, 1);

      run_op(4'd6, 4'd1, 1'b1, 0, 1'b0, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
